// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter for 8 requesters with a hold limit that forces rotation.
// The winner is kept as a 3-bit id and decoded to a registered one-hot grant.
module rr_decode_arbiter #(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   output logic [7:0] grant,
   output logic [2:0] grant_id,
   output logic       grant_valid,
   output logic       forced
);

   localparam int unsigned N   = 8;
   localparam int unsigned IDW = 3;
   localparam int unsigned HW  = $clog2(MAX_HOLD) + 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t           state_q, state_d;
   logic [IDW-1:0]   ptr_q, ptr_d;
   logic [HW-1:0]    hold_q, hold_d;
   logic [IDW-1:0]   id_d;
   logic [7:0]       grant_d;
   logic             valid_d;
   logic             forced_d;

   logic [7:0]       cand;
   logic [IDW-1:0]   win;
   logic             found;

   // Rotating search from ptr; the current owner never competes for a handoff.
   always_comb begin
      cand  = req;
      win   = '0;
      found = 1'b0;
      if (state_q == GRANT) begin
         cand[grant_id] = 1'b0;
      end
      for (int unsigned i = 0; i < N; i++) begin
         if (!found && cand[ptr_q + IDW'(i)]) begin
            win   = ptr_q + IDW'(i);
            found = 1'b1;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      hold_d   = hold_q;
      id_d     = grant_id;
      forced_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d = GRANT;
               id_d    = win;
               ptr_d   = win + IDW'(1);
               hold_d  = '0;
            end
         end
         GRANT: begin
            if (req[grant_id]) begin
               if (hold_q < HOLD_LAST) begin
                  hold_d = hold_q + HW'(1);
               end else if (found) begin
                  id_d     = win;
                  ptr_d    = win + IDW'(1);
                  hold_d   = '0;
                  forced_d = 1'b1;
               end
            end else if (found) begin
               id_d   = win;
               ptr_d  = win + IDW'(1);
               hold_d = '0;
            end else begin
               state_d = IDLE;
               hold_d  = '0;
            end
         end
         default: state_d = IDLE;
      endcase
      valid_d = (state_d == GRANT);
      grant_d = valid_d ? (8'(1) << id_d) : 8'h00;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         hold_q      <= '0;
         grant       <= '0;
         grant_id    <= '0;
         grant_valid <= 1'b0;
         forced      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         hold_q      <= hold_d;
         grant       <= grant_d;
         grant_id    <= id_d;
         grant_valid <= valid_d;
         forced      <= forced_d;
      end
   end

endmodule
